// File: rtl/ebi_mem_bridge.sv
// EBI-to-RAM bridge: turns each EBI read/write cycle into one single-cycle RAM access.
// Optional EBI_BRIDGE_STATS_EN adds saturating write/read access counters.
//
// state    | meaning
// IDLE     | waiting for a re/we rising edge
// WR       | ram_we_o strobe cycle
// RD_WAIT  | ram_re_o issued, counting down RAM read latency
// RD_HOLD  | read data driven onto EBI until re_i drops
// WAIT_LOW | access done (or error), waiting for the EBI cycle to end
module ebi_mem_bridge #(
    parameter int AW     = 22,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [3:0]    be_n_i,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic [3:0]    ram_be_o,
    output logic          ram_we_o,
    output logic          ram_re_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          rdata_oe_o,
    output logic          busy_o,
    output logic          err_o
`ifdef EBI_BRIDGE_STATS_EN
    ,
    output logic [15:0]   wr_cnt_o,
    output logic [15:0]   rd_cnt_o
`endif
);

    localparam int CW = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_HOLD,
        WAIT_LOW
    } state_t;

    state_t        state_q, state_d;
    logic          re_q, we_q;
    logic          re_rise, we_rise;
    logic [CW-1:0] cnt_q;
    logic          rd_drop_q;
    logic          cap_wr, cap_rd, set_err, sample, oe_set, oe_clr, cnt_dec;

    assign re_rise = re_i & ~re_q;
    assign we_rise = we_i & ~we_q;
    assign busy_o  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cap_wr  = 1'b0;
        cap_rd  = 1'b0;
        set_err = 1'b0;
        sample  = 1'b0;
        oe_set  = 1'b0;
        oe_clr  = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (re_rise && we_rise) begin
                    set_err = 1'b1;
                    state_d = WAIT_LOW;
                end else if (we_rise) begin
                    cap_wr  = 1'b1;
                    state_d = WR;
                end else if (re_rise) begin
                    cap_rd  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            WR: state_d = WAIT_LOW;
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    sample = 1'b1;
                    // An EBI cycle that already ended gets its data latched but never driven.
                    if (re_i && !rd_drop_q) begin
                        oe_set  = 1'b1;
                        state_d = RD_HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_HOLD: begin
                if (!re_i) begin
                    oe_clr  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!re_i && !we_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rd_drop_q   <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_be_o    <= '0;
            ram_we_o    <= 1'b0;
            ram_re_o    <= 1'b0;
            rdata_o     <= '0;
            rdata_oe_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q  <= state_d;
            re_q     <= re_i;
            we_q     <= we_i;
            ram_we_o <= cap_wr;
            ram_re_o <= cap_rd;
            err_o    <= set_err;
            if (cap_wr) begin
                ram_addr_o  <= addr_i;
                ram_wdata_o <= wdata_i;
                ram_be_o    <= ~be_n_i;
            end
            if (cap_rd) begin
                ram_addr_o <= addr_i;
                cnt_q      <= CW'(RD_LAT);
                rd_drop_q  <= 1'b0;
            end else begin
                if (cnt_dec) cnt_q <= cnt_q - 3'd1;
                if (state_q == RD_WAIT && !re_i) rd_drop_q <= 1'b1;
            end
            if (sample) rdata_o <= ram_rdata_i;
            if (oe_set) rdata_oe_o <= 1'b1;
            else if (oe_clr) rdata_oe_o <= 1'b0;
        end
    end

`ifdef EBI_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_o <= '0;
            rd_cnt_o <= '0;
        end else begin
            if (ram_we_o && wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
            if (sample && rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
        end
    end
`endif

endmodule
